// File: rtl/bitwise_logic_pipe.sv
// bitwise_logic_pipe: eight-way bitwise operator behind a one-deep valid/ready
// output register, with an optional multi-beat accumulate mode that folds a
// stream of A operands into one result using the op latched on the first beat.
module bitwise_logic_pipe #(
  parameter int WIDTH = 8
) (
  input  logic             clk,
  input  logic             reset,
  input  logic [2:0]       op,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [WIDTH-1:0] in_a,
  input  logic [WIDTH-1:0] in_b,
  input  logic             in_acc,
  input  logic             in_last,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] out_data,
  output logic             out_zero,
  output logic             out_ones,
  output logic             busy
);

  typedef enum logic {S_IDLE, S_ACC} state_t;

  state_t           r_state;
  logic [WIDTH-1:0] r_acc;
  logic [2:0]       r_op;
  logic             r_out_valid;
  logic [WIDTH-1:0] r_out_data;
  logic             r_out_zero;
  logic             r_out_ones;

  logic             w_accept;
  logic             w_produce;
  logic             w_load;
  logic [WIDTH-1:0] w_res;

  function automatic logic [WIDTH-1:0] f_op(input logic [2:0] o,
                                            input logic [WIDTH-1:0] x,
                                            input logic [WIDTH-1:0] y);
    logic [WIDTH-1:0] r;
    case (o)
      3'd0:    r = x & y;
      3'd1:    r = x | y;
      3'd2:    r = x ^ y;
      3'd3:    r = ~(x & y);
      3'd4:    r = ~(x | y);
      3'd5:    r = ~(x ^ y);
      3'd6:    r = x & ~y;
      default: r = x;
    endcase
    return r;
  endfunction

  // Ready depends only on output occupancy and downstream ready, never on in_valid
  assign in_ready = !r_out_valid || out_ready;
  assign w_accept = in_valid && in_ready;

  // Result of the current beat: fresh operands in IDLE, fold into accumulator in ACC
  always_comb begin
    w_res     = '0;
    w_produce = 1'b0;
    if (r_state == S_ACC) begin
      w_res     = f_op(r_op, r_acc, in_a);
      w_produce = in_last;
    end else begin
      w_res     = f_op(op, in_a, in_b);
      w_produce = !in_acc || in_last;
    end
  end

  assign w_load = w_accept && w_produce;

  // Accumulation state: enter ACC on a non-final acc beat, leave on the last beat
  always_ff @(posedge clk) begin
    if (reset) begin
      r_state <= S_IDLE;
      r_acc   <= '0;
      r_op    <= '0;
    end else if (w_accept) begin
      case (r_state)
        S_IDLE: begin
          if (in_acc && !in_last) begin
            r_acc   <= w_res;
            r_op    <= op;
            r_state <= S_ACC;
          end
        end
        default: begin
          if (in_last) r_state <= S_IDLE;
          else         r_acc   <= w_res;
        end
      endcase
    end
  end

  // Output register: load wins over drain so back-to-back results stream at full rate
  always_ff @(posedge clk) begin
    if (reset) begin
      r_out_valid <= 1'b0;
      r_out_data  <= '0;
      r_out_zero  <= 1'b0;
      r_out_ones  <= 1'b0;
    end else if (w_load) begin
      r_out_valid <= 1'b1;
      r_out_data  <= w_res;
      r_out_zero  <= (w_res == '0);
      r_out_ones  <= (w_res == '1);
    end else if (r_out_valid && out_ready) begin
      r_out_valid <= 1'b0;
    end
  end

  assign out_valid = r_out_valid;
  assign out_data  = r_out_data;
  assign out_zero  = r_out_zero;
  assign out_ones  = r_out_ones;
  assign busy      = (r_state == S_ACC);

endmodule
